multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore state machine that sequences the multicycle ARM datapath: shared instruction/data memory, instruction register, single ALU reused for PC+4 and address/data operations.
- Decodes op/funct from the latched instruction and produces per-cycle datapath selects and write strobes.
- Handles memory wait states through a mem_ready handshake and counts retired instructions.
- Sits in the control unit in place of the single-cycle main decoder. The existing ALU decoder and conditional logic consume its alu_op, reg_w, mem_w, branch and next_pc outputs.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- op  in  2  instr[27:26] from instruction register
- funct  in  6  instr[25:20] from instruction register
- mem_ready  in  1  memory completes current access this cycle
- ir_write  out  1  load instruction register
- next_pc  out  1  PC write request (PC <- ALU result)
- adr_src  out  1  memory address: 0=PC, 1=ALU-result register
- alu_src_a  out  2  00=register A, 01=PC
- alu_src_b  out  2  00=register B, 01=extended immediate, 10=constant 4
- result_src  out  2  00=ALU-out register, 01=data register, 10=ALU result
- alu_op  out  1  1 = ALU decoder uses funct (DP), 0 = add
- reg_w  out  1  raw register-file write (before cond gating)
- mem_w  out  1  raw memory write (before cond gating)
- branch  out  1  raw branch (before cond gating)
- imms  out  2  immediate select: 00 DP, 01 mem, 10 branch
- reg_src  out  2  {str_src, branch_src}, as in the single-cycle decoder
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  sticky flag: op=11 decoded
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- All outputs except instr_count and illegal_op are combinational from the state register plus mem_ready. No output depends on op/funct except imms, reg_src and the DECODE/MEMADR next-state logic.
- Reset (async):
  - state=FETCH, instr_count=0, illegal_op=0.
  - While rst=1, force ir_write, next_pc, reg_w, mem_w, branch and instr_done to 0.
- FETCH:
  - adr_src=0, alu_src_a=01, alu_src_b=10, result_src=10, alu_op=0.
  - ir_write=next_pc=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay, with no strobes.
- DECODE:
  - alu_src_a=01, alu_src_b=10, result_src=10 (PC+8 for R15 reads).
  - op=01 -> MEMADR; op=00 & funct[5]=0 -> EXECUTER; op=00 & funct[5]=1 -> EXECUTEI; op=10 -> BRANCH.
  - op=11 -> FETCH, set illegal_op, no retire.
- MEMADR: alu_src_a=00, alu_src_b=01, alu_op=0. funct[0]=1 -> MEMREAD, else MEMWRITE.
- MEMREAD: adr_src=1. mem_ready=1 -> MEMWB, else stay.
- MEMWB: result_src=01, reg_w=1 -> FETCH, retire.
- MEMWRITE:
  - adr_src=1, mem_w=1 every cycle in state (held until accepted).
  - mem_ready=1 -> FETCH, retire; else stay.
- EXECUTER: alu_src_a=00, alu_src_b=00, alu_op=1 -> ALUWB.
- EXECUTEI: alu_src_a=00, alu_src_b=01, alu_op=1 -> ALUWB.
- ALUWB: result_src=00, reg_w=1 -> FETCH, retire.
- BRANCH: alu_src_a=00, alu_src_b=01, result_src=10, branch=1 -> FETCH, retire.
- Unlisted outputs are 0 in every state. Unreachable state encodings -> FETCH.
- imms and reg_src: same op/funct mapping as the single-cycle main decoder, valid from DECODE onward.
- Retire:
  - instr_done=1 in the last cycle of the instruction (the transition to FETCH).
  - instr_count increments on the same clock edge and wraps from all-ones to 0.
- Latencies with mem_ready always 1: DP=4 cycles, LDR=5, STR=4, B=3.
- Reset mid-instruction aborts: no strobe is asserted after rst rises, and the next instruction starts at FETCH.

Decomposition:
- Package mc_ctrl_pkg:
  - typedef enum state_t (10 states).
  - localparams OP_DP=2'b00, OP_MEM=2'b01, OP_B=2'b10.
  - Select encodings ADR_PC/ADR_RES, SRCA_*, SRCB_*, RES_*.
- One sub-module, mc_ctrl_output_decoder: purely combinational map state_t + mem_ready -> control word. The top holds the state register, next-state logic, counter and flags.

Test Plan:
- Reset with rst=1 asserted mid-EXECUTER -> outputs strobe-free immediately; after release state=FETCH, instr_count=0, illegal_op=0.
- ADD reg (op=00, funct=000000), mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB; reg_w=1 only in cycle 4; instr_done pulse cycle 4; instr_count=1.
- LDR (op=01, funct[0]=1) with mem_ready held 0 for 2 cycles in MEMREAD -> MEMREAD lasts 3 cycles; reg_w in MEMWB only; total 7 cycles.
- STR (op=01, funct[0]=0) with mem_ready 0 for 3 cycles -> mem_w=1 for 4 consecutive cycles; adr_src=1; reg_w never 1.
- B (op=10) -> FETCH, DECODE, BRANCH; branch=1 one cycle; imms=10; reg_src=01. FETCH with mem_ready=0 for 2 cycles -> ir_write/next_pc stay 0 until mem_ready.
- op=11 -> illegal_op=1 sticky, returns to FETCH, instr_count unchanged. With CNT_W=4 and 16 retires -> instr_count wraps to 0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADR    = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECUTER  = 4'd6,
    EXECUTEI  = 4'd7,
    ALUWB     = 4'd8,
    BRANCH    = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic       ADR_PC  = 1'b0;
  localparam logic       ADR_RES = 1'b1;

  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Per-cycle datapath control word produced from the current state.
  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       instr_done;
  } ctrl_t;

  // Immediate extender select, identical to the single-cycle decoder.
  function automatic logic [1:0] imm_sel(input logic [1:0] op);
    case (op)
      OP_MEM:  return IMM_MEM;
      OP_B:    return IMM_BR;
      default: return IMM_DP;
    endcase
  endfunction

  // Register-read source {str_src, branch_src}; ld is funct[0] (L bit).
  function automatic logic [1:0] reg_sel(input logic [1:0] op, input logic ld);
    case (op)
      OP_MEM:  return ld ? 2'b00 : 2'b10;
      OP_B:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle.
// Latency: n/a (wiring only).
// Backpressure: memory stalls are signalled through mem_ready.
interface multicycle_controller_if #(parameter int CNT_W = 32);
  logic [1:0]       op;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             ir_write;
  logic             next_pc;
  logic             adr_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       result_src;
  logic             alu_op;
  logic             reg_w;
  logic             mem_w;
  logic             branch;
  logic [1:0]       imms;
  logic [1:0]       reg_src;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  // Controller side.
  modport master (
    input  op, funct, mem_ready,
    output ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
           alu_op, reg_w, mem_w, branch, imms, reg_src, instr_done,
           illegal_op, instr_count
  );

  // Datapath side.
  modport slave (
    output op, funct, mem_ready,
    input  ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
           alu_op, reg_w, mem_w, branch, imms, reg_src, instr_done,
           illegal_op, instr_count
  );
endinterface

// File: rtl/multicycle_controller_output_decoder.sv
// Moore output map: state (+ mem_ready for wait states) -> control word.
// Latency: purely combinational.
// Backpressure: mem_ready gates FETCH strobes and MEMWRITE retire.
module mc_ctrl_output_decoder
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Every field defaults to 0; each state only sets what it uses.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.next_pc    = mem_ready;
      end
      DECODE: begin
        // PC+8 is presented on result so R15 reads see the ARM pipeline view.
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMREAD: ctrl.adr_src = ADR_RES;
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWRITE: begin
        // Write held every cycle until memory accepts it.
        ctrl.adr_src    = ADR_RES;
        ctrl.mem_w      = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      EXECUTER: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = 1'b1;
      end
      EXECUTEI: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM: state register, next-state, retire counter, illegal flag.
// Latency: DP 4, LDR 5, STR 4, B 3 cycles with no memory wait states.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready; rst kills all strobes at once.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  multicycle_controller_if.master bus
);

  state_t           state;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] count;
  logic             illegal;

  mc_ctrl_output_decoder u_dec (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // State transitions, retire counting and sticky illegal-op capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      count   <= '0;
      illegal <= 1'b0;
    end else begin
      if (ctrl.instr_done) count <= count + CNT_W'(1);
      if (state == DECODE && bus.op == 2'b11) illegal <= 1'b1;
      case (state)
        FETCH:    if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_MEM:  state <= MEMADR;
            OP_DP:   state <= bus.funct[5] ? EXECUTEI : EXECUTER;
            OP_B:    state <= BRANCH;
            default: state <= FETCH;
          endcase
        end
        MEMADR:   state <= bus.funct[0] ? MEMREAD : MEMWRITE;
        MEMREAD:  if (bus.mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (bus.mem_ready) state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  // Strobes are masked by rst so an abort is visible in the same cycle.
  assign bus.ir_write   = ctrl.ir_write   & ~rst;
  assign bus.next_pc    = ctrl.next_pc    & ~rst;
  assign bus.reg_w      = ctrl.reg_w      & ~rst;
  assign bus.mem_w      = ctrl.mem_w      & ~rst;
  assign bus.branch     = ctrl.branch     & ~rst;
  assign bus.instr_done = ctrl.instr_done & ~rst;

  assign bus.adr_src    = ctrl.adr_src;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.result_src = ctrl.result_src;
  assign bus.alu_op     = ctrl.alu_op;

  assign bus.imms        = imm_sel(bus.op);
  assign bus.reg_src     = reg_sel(bus.op, bus.funct[0]);
  assign bus.illegal_op  = illegal;
  assign bus.instr_count = count;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller (CNT_W=4).
// Latency: expected per-cycle control words queued with their mem_ready stimulus.
// Backpressure: wait states injected via the queued mem_ready pattern.
module tb_multicycle_controller;

  typedef enum int {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AW, T_BR} tst_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tot = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  bit          rdy_q[$];
  logic [13:0] exp_q[$];
  string       tag_q[$];

  multicycle_controller_if #(.CNT_W(4)) bus();

  multicycle_controller #(.CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // {ir_write,next_pc,adr_src,a[2],b[2],res[2],alu_op,reg_w,mem_w,branch,done}
  function automatic logic [13:0] exp_vec(input tst_t s, input bit r);
    case (s)
      T_F:   return {r, r, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 4'b0000};
      T_D:   return {3'b000, 2'b01, 2'b10, 2'b10, 1'b0, 4'b0000};
      T_MA:  return {3'b000, 2'b00, 2'b01, 2'b00, 1'b0, 4'b0000};
      T_MR:  return {3'b001, 2'b00, 2'b00, 2'b00, 1'b0, 4'b0000};
      T_MWB: return {3'b000, 2'b00, 2'b00, 2'b01, 1'b0, 4'b1001};
      T_MW:  return {3'b001, 2'b00, 2'b00, 2'b00, 1'b0, 3'b010, r};
      T_ER:  return {3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 4'b0000};
      T_EI:  return {3'b000, 2'b00, 2'b01, 2'b00, 1'b1, 4'b0000};
      T_AW:  return {3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 4'b1001};
      T_BR:  return {3'b000, 2'b00, 2'b01, 2'b10, 1'b0, 4'b0011};
      default: return '0;
    endcase
  endfunction

  function automatic logic [13:0] act_vec();
    return {bus.ir_write, bus.next_pc, bus.adr_src, bus.alu_src_a, bus.alu_src_b,
            bus.result_src, bus.alu_op, bus.reg_w, bus.mem_w, bus.branch, bus.instr_done};
  endfunction

  function automatic logic [5:0] act_strobes();
    return {bus.ir_write, bus.next_pc, bus.reg_w, bus.mem_w, bus.branch, bus.instr_done};
  endfunction

  task automatic push(input tst_t s, input bit r, input string tag);
    rdy_q.push_back(r);
    exp_q.push_back(exp_vec(s, r));
    tag_q.push_back($sformatf("%s_c%0d", tag, tag_q.size() + 1));
  endtask

  // Drive queued mem_ready, compare outputs at negedge; starts/ends at posedge+1.
  task automatic drain();
    while (rdy_q.size() > 0) begin
      bus.mem_ready = rdy_q.pop_front();
      @(negedge clk);
      chk(tag_q.pop_front(), 32'(act_vec()), 32'(exp_q.pop_front()));
      @(posedge clk);
      #1;
    end
    tag_q.delete();
  endtask

  task automatic check_after(input string nm, input logic [1:0] imms, input logic [1:0] rs);
    chk({nm, "_cnt"}, 32'(bus.instr_count), 32'(exp_cnt % 16));
    chk({nm, "_imms"}, 32'(bus.imms), 32'(imms));
    chk({nm, "_regsrc"}, 32'(bus.reg_src), 32'(rs));
  endtask

  task automatic do_dp(input bit imm, input string nm);
    bus.op = 2'b00;
    bus.funct = imm ? 6'b101000 : 6'b000000;
    push(T_F, 1, nm); push(T_D, 1, nm); push(imm ? T_EI : T_ER, 1, nm); push(T_AW, 1, nm);
    drain();
    exp_cnt++;
    check_after(nm, 2'b00, 2'b00);
  endtask

  task automatic do_ldr(input int w, input string nm);
    bus.op = 2'b01;
    bus.funct = 6'b011001;
    push(T_F, 1, nm); push(T_D, 1, nm); push(T_MA, 1, nm);
    for (int i = 0; i < w; i++) push(T_MR, 0, nm);
    push(T_MR, 1, nm); push(T_MWB, 1, nm);
    drain();
    exp_cnt++;
    check_after(nm, 2'b01, 2'b00);
  endtask

  task automatic do_str(input int w, input string nm);
    bus.op = 2'b01;
    bus.funct = 6'b011000;
    push(T_F, 1, nm); push(T_D, 1, nm); push(T_MA, 1, nm);
    for (int i = 0; i < w; i++) push(T_MW, 0, nm);
    push(T_MW, 1, nm);
    drain();
    exp_cnt++;
    check_after(nm, 2'b01, 2'b10);
  endtask

  task automatic do_b(input int fw, input string nm);
    bus.op = 2'b10;
    bus.funct = 6'b000000;
    for (int i = 0; i < fw; i++) push(T_F, 0, nm);
    push(T_F, 1, nm); push(T_D, 1, nm); push(T_BR, 1, nm);
    drain();
    exp_cnt++;
    check_after(nm, 2'b10, 2'b01);
  endtask

  // Assert rst mid-cycle, check strobes vanish, hold one edge, release.
  task automatic abort_now(input string nm);
    #2 rst = 1'b1;
    #1 chk({nm, "_strobes_now"}, 32'(act_strobes()), 32'd0);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_strobes_held"}, 32'(act_strobes()), 32'd0);
    chk({nm, "_cnt_rst"}, 32'(bus.instr_count), 32'd0);
    chk({nm, "_ill_rst"}, 32'(bus.illegal_op), 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.op = 2'b00;
    bus.funct = 6'b000000;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", 32'(act_strobes()), 32'd0);
    chk("reset_cnt", 32'(bus.instr_count), 32'd0);
    chk("reset_ill", 32'(bus.illegal_op), 32'd0);
    rst = 1'b0;

    do_dp(1'b0, "add");
    do_ldr(2, "ldr_w2");
    do_str(3, "str_w3");
    do_b(2, "b_fw2");
    do_dp(1'b1, "addi");
    do_ldr(0, "ldr_w0");

    // Illegal opcode: two cycles, back to FETCH, no retire, sticky flag.
    chk("ill_before", 32'(bus.illegal_op), 32'd0);
    bus.op = 2'b11;
    bus.funct = 6'b000000;
    push(T_F, 1, "ill"); push(T_D, 1, "ill");
    drain();
    chk("ill_set", 32'(bus.illegal_op), 32'd1);
    chk("ill_cnt", 32'(bus.instr_count), 32'(exp_cnt % 16));
    do_dp(1'b0, "after_ill");
    chk("ill_sticky", 32'(bus.illegal_op), 32'd1);

    // Reset while in EXECUTER.
    bus.op = 2'b00;
    bus.funct = 6'b000000;
    push(T_F, 1, "rx"); push(T_D, 1, "rx");
    drain();
    abort_now("rst_exec");
    do_dp(1'b0, "post_rst_exec");

    // Reset while MEMWRITE is driving mem_w.
    bus.op = 2'b01;
    bus.funct = 6'b000000;
    push(T_F, 1, "rw"); push(T_D, 1, "rw"); push(T_MA, 1, "rw");
    drain();
    bus.mem_ready = 1'b0;
    #1 chk("rst_mw_pre_memw", 32'(bus.mem_w), 32'd1);
    abort_now("rst_mw");
    do_b(0, "post_rst_mw");

    // Counter wraps: 15 more retires reach 0 mod 16.
    for (int i = 0; i < 14; i++) do_b(0, $sformatf("wrap%0d", i));
    chk("wrap_at_15", 32'(bus.instr_count), 32'd15);
    do_b(0, "wrap_last");
    chk("wrap_to_0", 32'(bus.instr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
